// File: rtl/auc_rand_pkg.sv
// Shared definitions for the rejection-sampling scalar generator:
// FSM states, curve orders and operand RAM slot addresses.
package auc_rand_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CHECK,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } rand_st_e;

    localparam logic [255:0] ORD_P256 =
        256'hFFFFFFFF00000000FFFFFFFFFFFFFFFFBCE6FAADA7179E84F3B9CAC2FC632551;
    localparam logic [255:0] ORD_ED25519 =
        (256'd1 << 252) + 256'h14DEF9DEA2F79CD65812631A5CF5D3ED;

    // Operand RAM slots used by the sequencer for generated scalars
    localparam int unsigned K_NUM = 11;
    localparam int unsigned D_NUM = 12;
    localparam int unsigned R_NUM = 13;

endpackage

// File: rtl/auc_rand_chk.sv
// Range check for a candidate scalar: accept iff 0 < r < n (unsigned).
module auc_rand_chk #(
    parameter int WIDTH = 256
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] n,
    output logic             accept
);

    assign accept = (r != '0) && (r < n);

endmodule

// File: rtl/auc_rand_mc.sv
// Multi-scalar nonce generator: pulls words from a random source, rejection-samples
// them into [1, n-1] and writes accepted scalars to consecutive operand RAM slots.
module auc_rand_mc
    import auc_rand_pkg::*;
#(
    parameter int WIDTH     = 256,
    parameter int ADDR      = 5,
    parameter int CNT_W     = 4,
    parameter int MAX_RETRY = 15,
    parameter int REJ_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rand_en,
    input  logic [CNT_W-1:0] rand_cnt,
    input  logic [ADDR-1:0]  rand_base,
    input  logic [WIDTH-1:0] rand_mod,
    input  logic             rand_abort,
    input  logic             src_vld,
    input  logic [WIDTH-1:0] src_dat,
    output logic             src_rdy,
    output logic             rand_busy,
    output logic             rand_vld,
    output logic             rand_err,
    output logic [REJ_W-1:0] rand_rej,
    output logic             rand_wen,
    output logic [ADDR-1:0]  rand_wadd,
    output logic [WIDTH-1:0] rand_wdat
);

    localparam int RTY_W = $clog2(MAX_RETRY + 1);

    rand_st_e         st;
    logic [CNT_W-1:0] cnt, idx;
    logic [ADDR-1:0]  base;
    logic [WIDTH-1:0] modn, rnd;
    logic [RTY_W-1:0] retry;
    logic [RTY_W-1:0] retry_nxt;
    logic             accept;

    auc_rand_chk #(.WIDTH(WIDTH)) u_chk (
        .r      (rnd),
        .n      (modn),
        .accept (accept)
    );

    assign retry_nxt = retry + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st       <= ST_IDLE;
            cnt      <= '0;
            idx      <= '0;
            base     <= '0;
            modn     <= '0;
            rnd      <= '0;
            retry    <= '0;
            rand_rej <= '0;
        end else if (st != ST_IDLE && rand_abort) begin
            st <= ST_IDLE;
        end else begin
            case (st)
                ST_IDLE: if (rand_en) begin
                    rand_rej <= '0;
                    if (rand_cnt == '0) begin
                        st <= ST_DONE;
                    end else begin
                        cnt   <= rand_cnt;
                        base  <= rand_base;
                        modn  <= rand_mod;
                        idx   <= '0;
                        retry <= '0;
                        st    <= ST_FETCH;
                    end
                end
                ST_FETCH: if (src_vld) begin
                    rnd <= src_dat;
                    st  <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (accept) begin
                        retry <= '0;
                        st    <= ST_WRITE;
                    end else begin
                        if (rand_rej != '1) rand_rej <= rand_rej + 1'b1;
                        retry <= retry_nxt;
                        st    <= (retry_nxt == RTY_W'(MAX_RETRY)) ? ST_ERR : ST_FETCH;
                    end
                end
                ST_WRITE: begin
                    if (idx == cnt - 1'b1) begin
                        st <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                        st  <= ST_FETCH;
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

    // Strobes decode straight from state so reset removes them without waiting for an edge
    assign src_rdy   = (st == ST_FETCH);
    assign rand_busy = (st != ST_IDLE);
    assign rand_vld  = (st == ST_DONE);
    assign rand_err  = (st == ST_ERR);
    assign rand_wen  = (st == ST_WRITE);
    assign rand_wadd = base + ADDR'(idx);
    assign rand_wdat = rnd;

endmodule

// File: tb/tb_auc_rand_mc.sv
// Randomized and directed bench for auc_rand_mc against a word-list reference model.
`timescale 1ns/1ps
module tb_auc_rand_mc;
    import auc_rand_pkg::*;

    localparam int WIDTH = 256, ADDR = 5, CNT_W = 4, MAX_RETRY = 15, REJ_W = 16;
    typedef logic [WIDTH-1:0] word_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             rand_en = 1'b0;
    logic [CNT_W-1:0] rand_cnt = '0;
    logic [ADDR-1:0]  rand_base = '0;
    word_t            rand_mod = '0;
    logic             rand_abort = 1'b0;
    logic             src_vld;
    word_t            src_dat;
    logic             src_rdy, rand_busy, rand_vld, rand_err, rand_wen;
    logic [REJ_W-1:0] rand_rej;
    logic [ADDR-1:0]  rand_wadd;
    word_t            rand_wdat;

    auc_rand_mc #(.WIDTH(WIDTH), .ADDR(ADDR), .CNT_W(CNT_W),
                  .MAX_RETRY(MAX_RETRY), .REJ_W(REJ_W)) dut (
        .clk(clk), .rst(rst), .rand_en(rand_en), .rand_cnt(rand_cnt),
        .rand_base(rand_base), .rand_mod(rand_mod), .rand_abort(rand_abort),
        .src_vld(src_vld), .src_dat(src_dat), .src_rdy(src_rdy),
        .rand_busy(rand_busy), .rand_vld(rand_vld), .rand_err(rand_err),
        .rand_rej(rand_rej), .rand_wen(rand_wen), .rand_wadd(rand_wadd),
        .rand_wdat(rand_wdat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_fail = 0;
    int t0 = 0;
    bit rnd_mode = 1'b0;
    word_t q[$];

    // Observed activity of the current request
    logic [ADDR-1:0] ob_a[$];
    word_t           ob_d[$];
    int ob_wcyc, n_vld, n_err, vld_cyc, err_cyc, n_fetch, n_rdy;

    // Reference expectations
    int    exp_a[$];
    word_t exp_d[$];
    int    exp_rej, exp_out, exp_fetch, exp_end;

    task automatic chk(input string tag, input word_t got, input word_t exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic word_t rnd256();
        word_t v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Source driver and output monitor; acts on the falling edge only
    initial begin
        src_vld = 1'b0;
        src_dat = '0;
        forever begin
            @(negedge clk);
            if (rand_wen) begin
                ob_a.push_back(rand_wadd);
                ob_d.push_back(rand_wdat);
                ob_wcyc = cyc - t0;
            end
            if (rand_vld) begin n_vld++; vld_cyc = cyc - t0; end
            if (rand_err) begin n_err++; err_cyc = cyc - t0; end
            if (src_rdy) n_rdy++;
            src_vld = (q.size() > 0) && (!rnd_mode || $urandom_range(0, 2) != 0);
            src_dat = (q.size() > 0) ? q[0] : '0;
            if (src_vld && src_rdy) begin
                n_fetch++;
                void'(q.pop_front());
            end
        end
    end

    // Consume words in order: each scalar takes words until one lies in [1, m-1],
    // giving up after MAX_RETRY consecutive misses. Fetch costs 2 cycles, write 1 more.
    task automatic model(input int c, input int b, input word_t m, input word_t w[$]);
        int k, r;
        word_t v;
        exp_a.delete(); exp_d.delete();
        exp_rej = 0; exp_out = 0; exp_fetch = 0; exp_end = 1; k = 0;
        for (int s = 0; s < c && exp_out == 0; s++) begin
            r = 0;
            while (exp_out == 0) begin
                if (k >= w.size()) begin exp_out = 3; break; end
                v = w[k]; k++; exp_fetch++;
                exp_end += 2;
                if (v != 0 && v < m) begin
                    exp_a.push_back((b + s) % (1 << ADDR));
                    exp_d.push_back(v);
                    exp_end += 1;
                    break;
                end
                exp_rej++; r++;
                if (r == MAX_RETRY) exp_out = 2;
            end
        end
        if (exp_out == 0) exp_out = 1;
    endtask

    task automatic start(input int c, input int b, input word_t m);
        @(negedge clk); #1;
        ob_a.delete(); ob_d.delete();
        n_vld = 0; n_err = 0; n_fetch = 0; n_rdy = 0;
        vld_cyc = -1; err_cyc = -1; ob_wcyc = -1;
        rand_en = 1'b1; rand_cnt = CNT_W'(c); rand_base = ADDR'(b); rand_mod = m;
        t0 = cyc;
        @(negedge clk); #1;
        rand_en = 1'b0;
        // Scramble request inputs: the block must work from its latched copies
        rand_cnt = CNT_W'($urandom); rand_base = ADDR'($urandom); rand_mod = rnd256();
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (rand_busy && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        if (rand_busy) chk("timeout_busy", 1, 0);
    endtask

    task automatic check_req(input string tag, input bit timing);
        int n;
        chk({tag, "_nwr"}, ob_a.size(), exp_a.size());
        n = (ob_a.size() < exp_a.size()) ? ob_a.size() : exp_a.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_wadd"}, ob_a[i], exp_a[i]);
            chk({tag, "_wdat"}, ob_d[i], exp_d[i]);
        end
        chk({tag, "_rej"}, rand_rej, exp_rej);
        chk({tag, "_vld"}, n_vld, (exp_out == 1) ? 1 : 0);
        chk({tag, "_err"}, n_err, (exp_out == 2) ? 1 : 0);
        chk({tag, "_fetch"}, n_fetch, exp_fetch);
        if (timing) chk({tag, "_end"}, (exp_out == 1) ? vld_cyc : err_cyc, exp_end);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        word_t w[$];
        int c, b;
        word_t m;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", rand_busy, 0);
        chk("rst_rdy", src_rdy, 0);
        chk("rst_wen", rand_wen, 0);
        chk("rst_vld", rand_vld, 0);
        chk("rst_err", rand_err, 0);
        chk("rst_rej", rand_rej, 0);
        chk("rst_wadd", rand_wadd, 0);
        chk("rst_wdat", rand_wdat, 0);
        rst = 1'b1;

        // Single scalar, held-valid source
        rnd_mode = 0;
        w = '{word_t'(256'h1234)};
        q = w; model(1, K_NUM, ORD_P256, w);
        start(1, K_NUM, ORD_P256); wait_idle(100);
        check_req("p256", 1);
        chk("p256_wcyc", ob_wcyc, 3);
        chk("p256_vcyc", vld_cyc, 4);
        q.delete();

        // Two rejections (0 and n itself) before n-1 is accepted
        w = '{word_t'(0), ORD_P256, ORD_P256 - 1};
        q = w; model(1, K_NUM, ORD_P256, w);
        start(1, K_NUM, ORD_P256); wait_idle(100);
        check_req("rej", 1);
        chk("rej_vcyc", vld_cyc, 8);
        q.delete();

        // Address wrap across the top of the RAM
        w = '{word_t'(5), word_t'(6), word_t'(7)};
        q = w; model(3, 30, ORD_ED25519, w);
        start(3, 30, ORD_ED25519); wait_idle(100);
        check_req("wrap", 1);
        chk("wrap_a2", (ob_a.size() == 3) ? ob_a[2] : 5'h1f, 0);
        chk("wrap_busy", rand_busy, 0);
        q.delete();

        // Modulus 1 rejects everything
        w.delete();
        for (int i = 0; i < 20; i++) w.push_back(rnd256());
        q = w; model(2, 4, word_t'(1), w);
        start(2, 4, word_t'(1)); wait_idle(200);
        check_req("retry", 1);
        chk("retry_rej", rand_rej, 15);
        q.delete();

        // Abort during the second fetch
        w.delete();
        for (int i = 0; i < 8; i++) w.push_back(word_t'(100 + i));
        q = w;
        start(4, 2, ORD_P256);
        for (int k = 0; k < 50 && !(src_rdy && ob_a.size() == 1); k++) begin
            @(negedge clk); #1;
        end
        rand_abort = 1'b1;
        @(negedge clk); #1;
        rand_abort = 1'b0;
        chk("abort_busy", rand_busy, 0);
        repeat (4) @(negedge clk);
        #1;
        chk("abort_nwr", ob_a.size(), 1);
        chk("abort_vld", n_vld, 0);
        chk("abort_err", n_err, 0);
        q.delete();

        // Asynchronous reset in the write cycle
        q = '{word_t'(55)};
        start(1, 7, ORD_P256);
        for (int k = 0; k < 20 && !rand_wen; k++) begin
            @(negedge clk); #1;
        end
        chk("arst_pre_wen", rand_wen, 1);
        rst = 1'b0;
        #1;
        chk("arst_wen", rand_wen, 0);
        chk("arst_busy", rand_busy, 0);
        chk("arst_wadd", rand_wadd, 0);
        @(negedge clk); #1;
        rst = 1'b1;
        q.delete();

        // Zero-count request: done without touching the source
        q = '{word_t'(5)};
        w = q; model(0, 9, ORD_P256, w);
        start(0, 9, ORD_P256); wait_idle(20);
        chk("zero_rdy", n_rdy, 0);
        chk("zero_vld", n_vld, 1);
        chk("zero_nwr", ob_a.size(), 0);
        chk("zero_vcyc", vld_cyc, exp_end);
        q.delete();

        // Start pulse while busy must not disturb the latched request
        w = '{word_t'(10), word_t'(20), word_t'(30), word_t'(40), word_t'(50), word_t'(60)};
        q = w; model(2, 3, ORD_P256, w);
        start(2, 3, ORD_P256);
        rand_en = 1'b1; rand_cnt = 5; rand_base = 20;
        @(negedge clk); #1;
        rand_en = 1'b0;
        wait_idle(100);
        check_req("busy_en", 1);
        q.delete();

        // Randomized requests with a gappy source
        rnd_mode = 1;
        for (int t = 0; t < 25; t++) begin
            case ($urandom_range(0, 3))
                0: m = ORD_P256;
                1: m = ORD_ED25519;
                2: m = word_t'($urandom_range(0, 300));
                default: m = rnd256() >> $urandom_range(0, 255);
            endcase
            c = $urandom_range(0, 5);
            b = $urandom_range(0, 31);
            w.delete();
            for (int i = 0; i < 80; i++) begin
                case ($urandom_range(0, 5))
                    0: w.push_back('0);
                    1: w.push_back(m);
                    2: w.push_back(m - 1);
                    3: w.push_back(rnd256());
                    4: w.push_back(word_t'($urandom_range(0, 400)));
                    default: w.push_back(rnd256() >> $urandom_range(0, 255));
                endcase
            end
            q = w; model(c, b, m, w);
            start(c, b, m); wait_idle(3000);
            check_req("rnd", 0);
            q.delete();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
